// File: rtl/scope_pkg.sv
// Shared types for the capture path: FSM state encoding and trigger slope codes.
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT_TRIG,
        POST,
        DONE
    } state_t;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/trig_detect.sv
// Level/slope trigger: remembers the previous accepted sample and flags a crossing
// of the threshold in the selected direction on the current accepted sample.
module trig_detect #(
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_sample_en,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic [DATA_WIDTH-1:0] i_level,
    input  logic                  i_slope,
    output logic                  o_trig_hit_c
);
    import scope_pkg::*;

    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  w_rise;
    logic                  w_fall;

    // A cleared history means the first sample after arm can never trigger.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev_valid <= 1'b0;
        end else if (i_sample_en) begin
            r_prev       <= i_sample;
            r_prev_valid <= 1'b1;
        end
    end

    always_comb begin
        w_rise       = (r_prev < i_level) && (i_sample >= i_level);
        w_fall       = (r_prev > i_level) && (i_sample <= i_level);
        o_trig_hit_c = i_sample_en && r_prev_valid &&
                       ((i_slope == SLOPE_FALL) ? w_fall : w_rise);
    end

endmodule

// File: rtl/capture_writer.sv
// Write side of the sample buffer: circular capture into RAM with a pre-trigger
// window, stopping once one full record (2**ADDR_WIDTH samples) has been stored.
module capture_writer #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_slope,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] start_addr
);
    import scope_pkg::*;

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PRE_MAX = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_level;
    logic                  r_slope;
    logic [ADDR_WIDTH-1:0] r_pretrig;
    logic                  r_force_pend;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_we;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic                  r_busy;
    logic                  r_triggered;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_start_addr;

    logic                  w_accept;
    logic                  w_trig_hit;
    logic                  w_trig_fire;
    logic [ADDR_WIDTH-1:0] w_pre_clamp;
    logic [CNT_W-1:0]      w_post_len;
    logic [CNT_W-1:0]      w_cnt_inc;

    // A sample arriving together with arm belongs to neither capture and is dropped.
    always_comb begin
        w_accept    = sample_valid && r_busy && !arm;
        w_pre_clamp = (pretrig >= PRE_MAX) ? PRE_MAX : pretrig;
        w_post_len  = CNT_W'(DEPTH) - {1'b0, r_pretrig};
        w_cnt_inc   = r_cnt + CNT_W'(1);
        w_trig_fire = w_accept && (r_state == WAIT_TRIG) &&
                      (w_trig_hit || force_trig || r_force_pend);
    end

    trig_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trig (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear      (arm),
        .i_sample_en  (w_accept),
        .i_sample     (sample),
        .i_level      (r_level),
        .i_slope      (r_slope),
        .o_trig_hit_c (w_trig_hit)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_wp         <= '0;
            r_cnt        <= '0;
            r_level      <= '0;
            r_slope      <= SLOPE_RISE;
            r_pretrig    <= '0;
            r_force_pend <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_din    <= '0;
            r_busy       <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_start_addr <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (w_accept) begin
                r_ram_we   <= 1'b1;
                r_ram_addr <= r_wp;
                r_ram_din  <= sample;
                r_wp       <= r_wp + ADDR_WIDTH'(1);
            end

            // Arm always wins, including over a capture already in flight.
            if (arm) begin
                r_level      <= trig_level;
                r_slope      <= trig_slope;
                r_pretrig    <= w_pre_clamp;
                r_cnt        <= '0;
                r_force_pend <= 1'b0;
                r_triggered  <= 1'b0;
                r_done       <= 1'b0;
                r_busy       <= 1'b1;
                r_state      <= (w_pre_clamp == '0) ? WAIT_TRIG : PREFILL;
            end else begin
                case (r_state)
                    PREFILL: begin
                        if (w_accept) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == {1'b0, r_pretrig}) begin
                                r_state <= WAIT_TRIG;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (w_trig_fire) begin
                            r_start_addr <= r_wp - r_pretrig;
                            r_triggered  <= 1'b1;
                            r_force_pend <= 1'b0;
                            r_cnt        <= CNT_W'(1);
                            // Maximum pre-trigger window: the trigger sample completes the record.
                            if (w_post_len == CNT_W'(1)) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= POST;
                            end
                        end else if (force_trig) begin
                            r_force_pend <= 1'b1;
                        end
                    end
                    POST: begin
                        if (w_accept) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == w_post_len) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_din    = r_ram_din;
    assign busy       = r_busy;
    assign triggered  = r_triggered;
    assign done       = r_done;
    assign start_addr = r_start_addr;

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer at depth 16: table of full captures checked
// against a bench-side RAM image, plus sequences for re-arm, prev-invalid and reset.
module tb_capture_writer;
    import scope_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 12;
    localparam int unsigned DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample = '0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_slope = 1'b0;
    logic [AW-1:0] pretrig = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] start_addr;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int exp_wp = 0;
    logic [DW-1:0] ram_mem [DEPTH];

    typedef struct {
        int   kind;       // 0 ramp, 1 flat zero, 2 falling 9,7,5,3,3..
        int   pre;
        int   lvl;
        logic slp;
        int   force_idx;  // sample index carrying force_trig, -1 none
        logic gap;        // sample_valid one cycle in three
        int   exp_start;
        int   exp_nwr;
    } vec_t;

    vec_t vecs [8];

    capture_writer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .arm          (arm),
        .force_trig   (force_trig),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .pretrig      (pretrig),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .start_addr   (start_addr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // RAM image and write-address sequence: addresses must run consecutively from reset.
    always @(posedge clock) begin
        if (!reset_n) begin
            exp_wp = 0;
        end else if (ram_we) begin
            check("wr_addr", int'(ram_addr), exp_wp % DEPTH);
            ram_mem[ram_addr] = ram_din;
            exp_wp++;
            wr_cnt++;
        end
    end

    function automatic logic [DW-1:0] gen(input int kind, input int base, input int i);
        case (kind)
            0:       return DW'(base + i);
            1:       return '0;
            default: return (i <= 3) ? DW'(9 - 2 * i) : DW'(3);
        endcase
    endfunction

    task automatic do_reset();
        arm          = 1'b0;
        force_trig   = 1'b0;
        sample_valid = 1'b1;
        sample       = DW'(7);
        reset_n      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_we", int'(ram_we), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_trig", int'(triggered), 0);
        check("rst_start", int'(start_addr), 0);
        sample_valid = 1'b0;
        #2 reset_n = 1'b1;
        wr_cnt = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_arm(input int pre, input int lvl, input logic slp, input logic with_sample);
        arm          = 1'b1;
        pretrig      = AW'(pre);
        trig_level   = DW'(lvl);
        trig_slope   = slp;
        sample_valid = with_sample;
        sample       = DW'(99);
        @(posedge clock);
        #1;
        arm          = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic send(input int val, input logic frc);
        sample_valid = 1'b1;
        sample       = DW'(val);
        force_trig   = frc;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
        force_trig   = 1'b0;
    endtask

    task automatic feed(input int kind, input int base, input int force_idx, input logic gap,
                        input int max_n, input logic stop_on_done);
        for (int i = 0; i < max_n; i++) begin
            if (gap) repeat (2) begin
                @(posedge clock);
                #1;
            end
            send(int'(gen(kind, base, i)), i == force_idx);
            if (stop_on_done && done) break;
        end
    endtask

    initial begin
        vecs[0] = '{0,  4,  8, SLOPE_RISE, -1, 1'b0, 4, 20};
        vecs[1] = '{1,  0,  0, SLOPE_RISE,  2, 1'b0, 2, 18};
        vecs[2] = '{2,  0,  5, SLOPE_FALL, -1, 1'b0, 2, 18};
        vecs[3] = '{0, 15, 20, SLOPE_RISE, -1, 1'b0, 5, 21};
        vecs[4] = '{0,  4,  8, SLOPE_RISE, -1, 1'b1, 4, 20};
        vecs[5] = '{0,  3, 10, SLOPE_RISE,  6, 1'b0, 3, 19};
        vecs[6] = '{0,  8, 12, SLOPE_RISE,  2, 1'b0, 4, 20};
        vecs[7] = '{0,  4,  8, SLOPE_RISE,  8, 1'b0, 4, 20};

        #2;
        for (int t = 0; t < 8; t++) begin
            do_reset();
            do_arm(vecs[t].pre, vecs[t].lvl, vecs[t].slp, 1'b0);
            check($sformatf("v%0d_busy_armed", t), int'(busy), 1);
            feed(vecs[t].kind, 0, vecs[t].force_idx, vecs[t].gap, 100, 1'b1);
            @(posedge clock);
            #1;
            // Samples offered after completion must not be written.
            feed(vecs[t].kind, 50, -1, 1'b0, 3, 1'b0);
            repeat (2) @(posedge clock);
            #1;
            check($sformatf("v%0d_done", t), int'(done), 1);
            check($sformatf("v%0d_trig", t), int'(triggered), 1);
            check($sformatf("v%0d_busy", t), int'(busy), 0);
            check($sformatf("v%0d_start", t), int'(start_addr), vecs[t].exp_start);
            check($sformatf("v%0d_nwr", t), wr_cnt, vecs[t].exp_nwr);
            for (int k = 0; k < 16; k++) begin
                int idx;
                idx = vecs[t].exp_nwr - 16 + k;
                check($sformatf("v%0d_ram%0d", t, idx % 16), int'(ram_mem[idx % 16]),
                      int'(gen(vecs[t].kind, 0, idx)));
            end
        end

        // First sample after arm has no valid predecessor; arm drops a coincident sample.
        do_reset();
        do_arm(0, 5, SLOPE_RISE, 1'b0);
        send(3, 1'b0);
        send(3, 1'b0);
        check("pi_no_trig_low", int'(triggered), 0);
        do_arm(0, 5, SLOPE_RISE, 1'b1);
        check("pi_arm_drop_we", int'(ram_we), 0);
        send(6, 1'b0);
        check("pi_first_no_trig", int'(triggered), 0);
        send(7, 1'b0);
        check("pi_above_no_trig", int'(triggered), 0);
        send(4, 1'b0);
        check("pi_below_no_trig", int'(triggered), 0);
        send(6, 1'b0);
        check("pi_cross_trig", int'(triggered), 1);
        check("pi_start", int'(start_addr), 5);
        check("pi_busy_post", int'(busy), 1);

        // Re-arm during POST restarts cleanly; the second capture completes.
        do_reset();
        do_arm(4, 8, SLOPE_RISE, 1'b0);
        feed(0, 0, -1, 1'b0, 12, 1'b0);
        check("ra_trig_before", int'(triggered), 1);
        check("ra_busy_before", int'(busy), 1);
        check("ra_start_before", int'(start_addr), 4);
        do_arm(4, 108, SLOPE_RISE, 1'b1);
        check("ra_busy", int'(busy), 1);
        check("ra_trig_clr", int'(triggered), 0);
        check("ra_done_clr", int'(done), 0);
        check("ra_drop_we", int'(ram_we), 0);
        check("ra_wp_cont", exp_wp, 12);
        wr_cnt = 0;
        feed(0, 100, -1, 1'b0, 100, 1'b1);
        @(posedge clock);
        #1;
        check("ra_done", int'(done), 1);
        check("ra_trig", int'(triggered), 1);
        check("ra_start", int'(start_addr), 0);
        check("ra_nwr", wr_cnt, 20);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("ra_ram%0d", k), int'(ram_mem[k]), 104 + k);
        end

        // Asynchronous reset mid-capture kills an issued write immediately.
        do_reset();
        do_arm(4, 8, SLOPE_RISE, 1'b0);
        feed(0, 0, -1, 1'b0, 5, 1'b0);
        sample_valid = 1'b1;
        sample       = DW'(5);
        @(posedge clock);
        #1;
        check("ar_we_before", int'(ram_we), 1);
        check("ar_busy_before", int'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_we", int'(ram_we), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_done", int'(done), 0);
        sample_valid = 1'b0;
        @(posedge clock);
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("ar_idle_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
